micro_sequencer: RTL and testbench

- Replacement instruction sequencer for the 8-bit bus CPU.
- Fully synchronous on a single clock edge; drives the 16-bit control word to the register, ALU, RAM, PC and output-register enables.
- Adds a captured flags register (carry, zero), conditional jumps JC/JZ, and early instruction termination after the last useful microstep.
- Adds a free-run / single-instruction-step mode and a sticky halt state.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/micro_decode.sv | 107 ++++++++++
 rtl/micro_sequencer.sv | 103 ++++++++++
 tb/tb_micro_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU control path:
// opcodes, control-word bit positions and sequencer states.
package cpu_pkg;

  localparam int CW_WIDTH = 16;

  // Opcodes (instruction register bits [7:4])
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Control-word bit indices
  localparam int CW_J   = 0;
  localparam int CW_CO  = 1;
  localparam int CW_CE  = 2;
  localparam int CW_OI  = 3;
  localparam int CW_BI  = 4;
  localparam int CW_SU  = 5;
  localparam int CW_SO  = 6;
  localparam int CW_AO  = 7;
  localparam int CW_AI  = 8;
  localparam int CW_II  = 9;
  localparam int CW_IO  = 10;
  localparam int CW_RO  = 11;
  localparam int CW_RI  = 12;
  localparam int CW_MI  = 13;
  localparam int CW_HLT = 14;
  localparam int CW_FI  = 15;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_EXEC = 2'd1,
    ST_HALT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/micro_decode.sv
// Combinational microcode ROM: maps (stage, opcode, flags) to the
// EXEC-state control word and flags the opcode's final stage.
module micro_decode
  import cpu_pkg::*;
#(
  parameter int MAX_STAGE = 4,
  parameter bit EARLY_END = 1'b1
) (
  input  logic [2:0]          i_stage,
  input  logic [3:0]          i_instruction,
  input  logic                i_carry_flag,
  input  logic                i_zero_flag,
  output logic [CW_WIDTH-1:0] o_ctrlwrd,
  output logic                o_last_stage
);

  logic [2:0] w_last;

  // Control word for the current microstep; unused stages emit zero.
  always_comb begin
    o_ctrlwrd = '0;
    case (i_stage)
      3'd0: begin
        o_ctrlwrd[CW_MI] = 1'b1;
        o_ctrlwrd[CW_CO] = 1'b1;
      end
      3'd1: begin
        o_ctrlwrd[CW_RO] = 1'b1;
        o_ctrlwrd[CW_II] = 1'b1;
        o_ctrlwrd[CW_CE] = 1'b1;
      end
      3'd2: begin
        case (i_instruction)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            o_ctrlwrd[CW_IO] = 1'b1;
            o_ctrlwrd[CW_MI] = 1'b1;
          end
          OP_LDI: begin
            o_ctrlwrd[CW_IO] = 1'b1;
            o_ctrlwrd[CW_AI] = 1'b1;
          end
          OP_JMP: begin
            o_ctrlwrd[CW_IO] = 1'b1;
            o_ctrlwrd[CW_J]  = 1'b1;
          end
          OP_JC: begin
            o_ctrlwrd[CW_IO] = i_carry_flag;
            o_ctrlwrd[CW_J]  = i_carry_flag;
          end
          OP_JZ: begin
            o_ctrlwrd[CW_IO] = i_zero_flag;
            o_ctrlwrd[CW_J]  = i_zero_flag;
          end
          OP_OUT: begin
            o_ctrlwrd[CW_AO] = 1'b1;
            o_ctrlwrd[CW_OI] = 1'b1;
          end
          OP_HLT: o_ctrlwrd[CW_HLT] = 1'b1;
          default: ;
        endcase
      end
      3'd3: begin
        case (i_instruction)
          OP_LDA: begin
            o_ctrlwrd[CW_RO] = 1'b1;
            o_ctrlwrd[CW_AI] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            o_ctrlwrd[CW_RO] = 1'b1;
            o_ctrlwrd[CW_BI] = 1'b1;
          end
          OP_STA: begin
            o_ctrlwrd[CW_AO] = 1'b1;
            o_ctrlwrd[CW_RI] = 1'b1;
          end
          default: ;
        endcase
      end
      3'd4: begin
        if (i_instruction == OP_ADD || i_instruction == OP_SUB) begin
          o_ctrlwrd[CW_SO] = 1'b1;
          o_ctrlwrd[CW_AI] = 1'b1;
          o_ctrlwrd[CW_FI] = 1'b1;
          o_ctrlwrd[CW_SU] = (i_instruction == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  // Final stage per opcode; not-taken jumps still end at stage 2.
  always_comb begin
    w_last = 3'd2;
    if (!EARLY_END) begin
      w_last = 3'(MAX_STAGE);
    end else begin
      case (i_instruction)
        OP_LDA, OP_STA: w_last = 3'd3;
        OP_ADD, OP_SUB: w_last = 3'd4;
        default:        w_last = 3'd2;
      endcase
    end
  end

  assign o_last_stage = (i_stage == w_last);

endmodule

// File: rtl/micro_sequencer.sv
// Instruction sequencer: WAIT/EXEC/HALT state machine, microstep counter,
// captured ALU flags and step-request edge detection.
module micro_sequencer
  import cpu_pkg::*;
#(
  parameter int MAX_STAGE = 4,
  parameter bit EARLY_END = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run_mode,
  input  logic                step,
  input  logic [3:0]          instruction,
  input  logic                alu_carry,
  input  logic                alu_zero,
  output logic [CW_WIDTH-1:0] ctrlwrd,
  output logic [2:0]          stage,
  output logic                halted,
  output logic                busy,
  output logic                carry_flag,
  output logic                zero_flag,
  output logic                instr_done
);

  seq_state_t          r_state;
  logic [2:0]          r_stage;
  logic                r_carry;
  logic                r_zero;
  logic                r_step_d;
  logic [CW_WIDTH-1:0] w_cw_exec;
  logic                w_last;
  logic                w_step_rise;

  micro_decode #(
    .MAX_STAGE (MAX_STAGE),
    .EARLY_END (EARLY_END)
  ) u_decode (
    .i_stage       (r_stage),
    .i_instruction (instruction),
    .i_carry_flag  (r_carry),
    .i_zero_flag   (r_zero),
    .o_ctrlwrd     (w_cw_exec),
    .o_last_stage  (w_last)
  );

  assign w_step_rise = step & ~r_step_d;

  // Delay step by one cycle for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_step_d <= 1'b0;
    else        r_step_d <= step;
  end

  // State machine, stage counter and flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT;
      r_stage <= 3'd0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          r_stage <= 3'd0;
          if (run_mode || w_step_rise) r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (w_cw_exec[CW_FI]) begin
            r_carry <= alu_carry;
            r_zero  <= alu_zero;
          end
          if (w_last) begin
            r_stage <= 3'd0;
            if (instruction == OP_HLT) r_state <= ST_HALT;
            else if (!run_mode)        r_state <= ST_WAIT;
          end else begin
            r_stage <= r_stage + 3'd1;
          end
        end
        ST_HALT: r_stage <= 3'd0;
        default: begin
          r_state <= ST_WAIT;
          r_stage <= 3'd0;
        end
      endcase
    end
  end

  // Output word: microcode in EXEC, HLT bit alone in HALT, idle otherwise.
  always_comb begin
    ctrlwrd = '0;
    if (r_state == ST_EXEC)      ctrlwrd = w_cw_exec;
    else if (r_state == ST_HALT) ctrlwrd[CW_HLT] = 1'b1;
  end

  assign stage      = r_stage;
  assign halted     = (r_state == ST_HALT);
  assign busy       = (r_state == ST_EXEC);
  assign carry_flag = r_carry;
  assign zero_flag  = r_zero;
  assign instr_done = (r_state == ST_EXEC) && w_last;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: one early-ending instance and one
// running every opcode to the full stage count.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run_mode, step, alu_carry, alu_zero;
  logic [3:0]  instruction;
  logic [15:0] ctrlwrd;
  logic [2:0]  stage;
  logic        halted, busy, carry_flag, zero_flag, instr_done;

  logic        rst_n2, run_mode2;
  logic [3:0]  instr2;
  logic [15:0] ctrlwrd2;
  logic [2:0]  stage2;
  logic        halted2, busy2, carry2, zero2, done2;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  micro_sequencer #(.MAX_STAGE(4), .EARLY_END(1'b1)) u_dut (
    .clk (clk), .rst_n (rst_n), .run_mode (run_mode), .step (step),
    .instruction (instruction), .alu_carry (alu_carry), .alu_zero (alu_zero),
    .ctrlwrd (ctrlwrd), .stage (stage), .halted (halted), .busy (busy),
    .carry_flag (carry_flag), .zero_flag (zero_flag), .instr_done (instr_done)
  );

  micro_sequencer #(.MAX_STAGE(4), .EARLY_END(1'b0)) u_dut_full (
    .clk (clk), .rst_n (rst_n2), .run_mode (run_mode2), .step (1'b0),
    .instruction (instr2), .alu_carry (alu_carry), .alu_zero (alu_zero),
    .ctrlwrd (ctrlwrd2), .stage (stage2), .halted (halted2), .busy (busy2),
    .carry_flag (carry2), .zero_flag (zero2), .instr_done (done2)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%04h", tag, got);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 0; run_mode = 0; step = 0; instruction = 4'h0;
    alu_carry = 0; alu_zero = 0;
    rst_n2 = 0; run_mode2 = 0; instr2 = 4'h0;
    tick(2);

    // Reset state
    check("rst_ctrlwrd", ctrlwrd, 16'h0000);
    check("rst_stage", {13'd0, stage}, 16'd0);
    check("rst_status", {11'd0, halted, busy, carry_flag, zero_flag, instr_done}, 16'd0);

    // Free-run LDA
    instruction = 4'b0001; run_mode = 1; rst_n = 1;
    check("lda_wait", ctrlwrd, 16'h0000);
    tick(); check("lda_s0", ctrlwrd, 16'h2002);
    tick(); check("lda_s1", ctrlwrd, 16'h0A04);
    tick(); check("lda_s2", ctrlwrd, 16'h2400);
    tick(); check("lda_s3", ctrlwrd, 16'h0900);
    check("lda_done", {12'd0, stage, instr_done}, {12'd0, 3'd3, 1'b1});
    tick(); check("lda_wrap", {12'd0, stage, busy}, {12'd0, 3'd0, 1'b1});

    // JC not taken (carry 0)
    instruction = 4'b0111;
    tick(2); check("jc_nt_s2", ctrlwrd, 16'h0000);
    check("jc_nt_done", {15'd0, instr_done}, 16'd1);

    // ADD with carry
    tick(); instruction = 4'b0010; alu_carry = 1; alu_zero = 0;
    tick(3); check("add_s3", ctrlwrd, 16'h0810);
    tick(); check("add_s4", ctrlwrd, 16'h8140);
    check("add_done", {15'd0, instr_done}, 16'd1);
    tick(); check("add_flags", {14'd0, carry_flag, zero_flag}, 16'b10);

    // JC taken
    instruction = 4'b0111;
    tick(2); check("jc_t_s2", ctrlwrd, 16'h0401);

    // SUB producing zero, no carry
    tick(); instruction = 4'b0011; alu_carry = 0; alu_zero = 1;
    tick(4); check("sub_s4", ctrlwrd, 16'h8160);
    tick(); check("sub_flags", {14'd0, carry_flag, zero_flag}, 16'b01);

    // JZ taken, switch to step mode at the boundary
    instruction = 4'b1000; run_mode = 0;
    tick(2); check("jz_t_s2", ctrlwrd, 16'h0401);
    tick(); check("to_wait", {12'd0, stage, busy}, 16'd0);
    tick(2); check("wait_idle", {15'd0, busy}, 16'd0);

    // Single step OUT; second pulse during EXEC discarded
    instruction = 4'b1110; step = 1;
    tick(); check("step_s0", {12'd0, stage, busy}, {12'd0, 3'd0, 1'b1});
    step = 0;
    tick(); step = 1;
    tick(); check("out_s2", ctrlwrd, 16'h0088);
    check("out_done", {15'd0, instr_done}, 16'd1);
    tick(); check("out_wait", {15'd0, busy}, 16'd0);
    step = 0;
    tick(3); check("step_ignored", {15'd0, busy}, 16'd0);
    step = 1;
    tick(); step = 0; check("step2_s0", {15'd0, busy}, 16'd1);
    tick(2); check("step2_s2", ctrlwrd, 16'h0088);
    tick(); check("step2_wait", {15'd0, busy}, 16'd0);
    tick(3); check("step2_once", {15'd0, busy}, 16'd0);

    // HLT and sticky halt
    instruction = 4'b1111; step = 1;
    tick(); step = 0;
    tick(2); check("hlt_s2", ctrlwrd, 16'h4000);
    tick(); check("halted", {15'd0, halted}, 16'd1);
    for (int i = 0; i < 20; i++) begin
      step = i[0]; run_mode = i[1];
      tick();
      check("halt_hold", {ctrlwrd[14:0], halted}, {15'h4000, 1'b1});
    end
    step = 0; run_mode = 0;
    #3 rst_n = 0; #1;
    check("hlt_rst_cw", ctrlwrd, 16'h0000);
    check("hlt_rst_st", {10'd0, stage, halted, busy, carry_flag, zero_flag, instr_done}, 16'd0);

    // Full-length instance: LDI runs to stage 4
    instr2 = 4'b0101; run_mode2 = 1; rst_n2 = 1;
    tick(3); check("ldi_s2", ctrlwrd2, 16'h0500);
    tick(); check("ldi_s3", {ctrlwrd2[14:0], done2}, 16'h0000);
    tick(); check("ldi_s4", ctrlwrd2, 16'h0000);
    check("ldi_done", {12'd0, stage2, done2}, {12'd0, 3'd4, 1'b1});

    // ADD sets carry, then reset at stage 3 of the next ADD
    tick(); instr2 = 4'b0010; alu_carry = 1; alu_zero = 0;
    tick(5); check("full_add_flag", {15'd0, carry2}, 16'd1);
    tick(3); check("full_add_s3", {13'd0, stage2}, 16'd3);
    #2 rst_n2 = 0; #1;
    check("abort_rst", {10'd0, stage2, busy2, carry2, zero2, done2, halted2}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
